abs_diff_approx_pipe: RTL and testbench
=======================================

// Module: abs_diff_approx_pipe
// PURPOSE
//   Parametrised, pipelined approximate absolute-difference unit: out = |a - b| with the
//   TRUNC least-significant result bits forced to zero, selectable per transaction.
//   Runtime error monitoring checks each approximate result against the exact result
//   and the error threshold ET. Sits between operand producers and consumers in the
//   approximate-datapath evaluation flow, with valid/ready handshakes on both sides.
// PARAMETERS
//   W        4   operand and result width (bits); result |a-b| fits in W bits
//   TRUNC    1   result LSBs zeroed in approximate mode; 0 <= TRUNC < W
//   ET       2   error threshold; |exact - approx| > ET counts as a violation
//   CNT_W    8   width of the violation counter (saturating)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit can accept a beat this cycle
//   in_a       in   W      operand a (unsigned)
//   in_b       in   W      operand b (unsigned)
//   in_approx  in   1      1 = approximate result, 0 = exact bypass (per beat)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   out_diff   out  W      result (approximate or exact)
//   out_viol   out  1      this beat's error exceeded ET (monitor builds only)
//   err_cnt    out  CNT_W  saturating count of violating beats (monitor builds only)
//   err_max    out  W      largest error seen since reset (monitor builds only)
// BEHAVIOUR
//   - Reset: all stage valid bits 0; out_valid=0, out_diff=0, out_viol=0, err_cnt=0, err_max=0.
//     Reset mid-operation discards in-flight beats; no output beat is produced for them.
//   - Two register stages, S1 and S2. Beat accepted when in_valid & in_ready.
//     S1 captures exact = (a>=b) ? a-b : b-a (W bits, no overflow) and in_approx.
//     S2 captures out_diff = approx ? {exact[W-1:TRUNC], TRUNC'b0} : exact;
//     err = exact - out_diff (always < 2^TRUNC); out_viol = (err > ET).
//   - Latency: 2 cycles acceptance-to-out_valid when not stalled; throughput 1 beat/cycle.
//   - Flow control: S2 advances when !s2_valid | out_ready; S1 advances when
//     !s1_valid | S2 advances; in_ready = !s1_valid | S2 advances (combinational
//     from out_ready; no combinational path from in_valid to in_ready).
//   - Stall: while out_valid & !out_ready, out_diff/out_viol hold stable; no beat lost
//     or duplicated; at most 2 beats in flight.
//   - Beat leaving S2 (out_valid & out_ready): err_cnt += out_viol, saturating at
//     2^CNT_W-1; err_max = max(err_max, err). Counted once per handshake, not per cycle.
//   - a == b -> result 0, err 0. TRUNC=0 -> approx identical to exact, viol never set.
//   - ET >= 2^TRUNC-1 -> violations impossible; counter stays 0 (legal configuration).
// CONFIGURATION
//   ABS_DIFF_ERR_MON_EN defined: out_viol, err_cnt, err_max as above; err datapath built.
//   Not defined: err datapath/registers removed; out_viol=0, err_cnt=0, err_max=0
//   constantly; out_diff, handshakes and latency unchanged.
// TESTING (W=4, TRUNC=1, ET=2 unless noted; monitor enabled unless noted)
//   1. a=9,b=2,approx=1, out_ready=1 -> 2 cycles later out_diff=6, out_viol=0; approx=0 -> 7.
//   2. a=3,b=12,approx=1 -> out_diff=8 (exact 9, err 1); a=b=5 -> out_diff=0, err_max unchanged.
//   3. TRUNC=3,ET=2: a=15,b=0,approx=1 -> out_diff=8, out_viol=1, err_cnt=1, err_max=7.
//   4. Back-to-back 10 beats, out_ready low for 5 cycles mid-stream -> in_ready drops,
//      all 10 results emerge in order, none dropped/duplicated, data stable while stalled.
//   5. CNT_W=2,TRUNC=3: 5 violating beats -> err_cnt saturates at 3; rst=1 one cycle with
//      2 beats in flight -> out_valid=0, err_cnt=0, err_max=0 next cycle, no stale beats.
//   6. ABS_DIFF_ERR_MON_EN undefined, rerun 3 -> out_diff=8, out_viol/err_cnt/err_max=0.

Source files
------------

// File: rtl/abs_diff_approx_pipe.sv
// rtl/abs_diff_approx_pipe.sv - pipelined approximate absolute-difference unit
//
// Purpose:
//   Two-stage valid/ready pipeline computing |a - b|. In approximate mode the
//   TRUNC least-significant result bits are forced to zero. An optional error
//   monitor (build macro ABS_DIFF_ERR_MON_EN) compares each approximate result
//   with the exact one, flags beats whose error exceeds ET, counts them in a
//   saturating counter and tracks the largest error seen since reset.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit can accept a beat this cycle
//   in_a       in   W      operand a (unsigned)
//   in_b       in   W      operand b (unsigned)
//   in_approx  in   1      1 = approximate result, 0 = exact (per beat)
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   out_diff   out  W      result
//   out_viol   out  1      this beat's error exceeded ET (monitor builds only)
//   err_cnt    out  CNT_W  saturating count of violating beats (monitor only)
//   err_max    out  W      largest error seen since reset (monitor only)

module abs_diff_approx_pipe #(
  parameter int W     = 4,
  parameter int TRUNC = 1,
  parameter int ET    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_diff,
  output logic             out_viol,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     err_max
);

  // Clears the truncated LSBs; with TRUNC=0 the mask is all ones.
  localparam logic [W-1:0] KEEP_MASK = {W{1'b1}} << TRUNC;

  logic         s1_valid;
  logic         s1_approx;
  logic [W-1:0] s1_exact;
  logic         s2_valid;
  logic [W-1:0] s2_diff;

  logic         s1_adv;
  logic         s2_adv;
  logic [W-1:0] exact_in;
  logic [W-1:0] diff_next;

  // in_ready depends on out_ready and stage state only, never on in_valid.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign exact_in  = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
  assign diff_next = s1_approx ? (s1_exact & KEEP_MASK) : s1_exact;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= 1'b0;
    end else if (s1_adv) begin
      s1_valid  <= in_valid;
      s1_exact  <= exact_in;
      s1_approx <= in_approx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_diff  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_diff  <= diff_next;
    end
  end

  assign out_valid = s2_valid;
  assign out_diff  = s2_diff;

`ifdef ABS_DIFF_ERR_MON_EN
  localparam int unsigned      ET_U    = ET;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     err_next;
  logic             viol_next;
  logic [W-1:0]     s2_err;
  logic             s2_viol;
  logic [CNT_W-1:0] err_cnt_q;
  logic [W-1:0]     err_max_q;
  logic             beat_done;

  // Truncation only removes low bits, so the error never underflows.
  assign err_next  = s1_exact - diff_next;
  assign viol_next = 32'(err_next) > ET_U;
  assign beat_done = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_err  <= '0;
      s2_viol <= 1'b0;
    end else if (s2_adv) begin
      s2_err  <= err_next;
      s2_viol <= viol_next;
    end
  end

  // Statistics update once per output handshake, not per stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else if (beat_done) begin
      if (s2_viol && (err_cnt_q != CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
      if (s2_err > err_max_q) begin
        err_max_q <= s2_err;
      end
    end
  end

  assign out_viol = s2_viol;
  assign err_cnt  = err_cnt_q;
  assign err_max  = err_max_q;
`else
  assign out_viol = 1'b0;
  assign err_cnt  = '0;
  assign err_max  = '0;
`endif

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// tb/tb_abs_diff_approx_pipe.sv - self-checking bench for abs_diff_approx_pipe

module tb_abs_diff_approx_pipe;

`ifdef ABS_DIFF_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  // u0: W=4 TRUNC=1 ET=2 CNT_W=8 ; u1: W=4 TRUNC=3 ET=2 CNT_W=2
  localparam int T0 = 1, T1 = 3, ETV = 2, CMAX0 = 255, CMAX1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v0, r0, ap0, ov0, or0, vi0;
  logic [3:0] a0, b0, d0, em0;
  logic [7:0] ec0;
  logic       v1, r1, ap1, ov1, or1, vi1;
  logic [3:0] a1, b1, d1, em1;
  logic [1:0] ec1;

  abs_diff_approx_pipe #(.W(4), .TRUNC(T0), .ET(ETV), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
    .in_approx(ap0), .out_valid(ov0), .out_ready(or0), .out_diff(d0),
    .out_viol(vi0), .err_cnt(ec0), .err_max(em0));

  abs_diff_approx_pipe #(.W(4), .TRUNC(T1), .ET(ETV), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_approx(ap1), .out_valid(ov1), .out_ready(or1), .out_diff(d1),
    .out_viol(vi1), .err_cnt(ec1), .err_max(em1));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: the result keeps only whole multiples of 2^trunc in approx mode.
  function automatic int m_exact(int a, int b);
    return (a >= b) ? a - b : b - a;
  endfunction
  function automatic int m_diff(int a, int b, int ap, int tr);
    int e;
    e = m_exact(a, b);
    return ap != 0 ? (e / (1 << tr)) * (1 << tr) : e;
  endfunction

  typedef struct { int diff; int err; int acc; } exp_t;
  exp_t q0[$], q1[$];
  int mcnt0 = 0, mmax0 = 0, mcnt1 = 0, mmax1 = 0;
  int nout0 = 0, nout1 = 0, last0_diff = 0, last1_diff = 0, last0_lat = 0;
  int last0_viol = 0, last1_viol = 0;
  bit saw_low0 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q0.delete(); mcnt0 = 0; mmax0 = 0;
    end else begin
      chk("u0_err_cnt", 32'(ec0), MON ? mcnt0 : 0);
      chk("u0_err_max", 32'(em0), MON ? mmax0 : 0);
      if (ov0) begin
        if (q0.size() == 0) chk("u0_spurious_beat", 32'd1, 32'd0);
        else begin
          e = q0[0];
          chk("u0_diff", 32'(d0), e.diff);
          chk("u0_viol", 32'(vi0), (MON && e.err > ETV) ? 1 : 0);
          if (or0) begin
            void'(q0.pop_front());
            nout0++; last0_diff = 32'(d0); last0_viol = 32'(vi0); last0_lat = cyc - e.acc;
            if (e.err > ETV && mcnt0 < CMAX0) mcnt0++;
            if (e.err > mmax0) mmax0 = e.err;
          end
        end
      end
      if (v0 && !r0) saw_low0 = 1'b1;
      if (v0 && r0) begin
        e.diff = m_diff(a0, b0, ap0, T0);
        e.err  = m_exact(a0, b0) - e.diff;
        e.acc  = cyc;
        q0.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete(); mcnt1 = 0; mmax1 = 0;
    end else begin
      chk("u1_err_cnt", 32'(ec1), MON ? mcnt1 : 0);
      chk("u1_err_max", 32'(em1), MON ? mmax1 : 0);
      if (ov1) begin
        if (q1.size() == 0) chk("u1_spurious_beat", 32'd1, 32'd0);
        else begin
          e = q1[0];
          chk("u1_diff", 32'(d1), e.diff);
          chk("u1_viol", 32'(vi1), (MON && e.err > ETV) ? 1 : 0);
          if (or1) begin
            void'(q1.pop_front());
            nout1++; last1_diff = 32'(d1); last1_viol = 32'(vi1);
            if (e.err > ETV && mcnt1 < CMAX1) mcnt1++;
            if (e.err > mmax1) mmax1 = e.err;
          end
        end
      end
      if (v1 && r1) begin
        e.diff = m_diff(a1, b1, ap1, T1);
        e.err  = m_exact(a1, b1) - e.diff;
        e.acc  = cyc;
        q1.push_back(e);
      end
    end
  end

  task automatic beat0(input int a, input int b, input int ap);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    v0 = 1'b1; a0 = 4'(a); b0 = 4'(b); ap0 = ap[0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u0_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic beat1(input int a, input int b, input int ap);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b1; a1 = 4'(a); b1 = 4'(b); ap1 = ap[0];
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("u1_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle0();
    @(posedge clk); #1; v0 = 1'b0;
  endtask
  task automatic idle1();
    @(posedge clk); #1; v1 = 1'b0;
  endtask

  task automatic wait_out0(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (nout0 >= n) return;
    end
    chk("u0_output_timeout", 32'(nout0), 32'(n));
  endtask
  task automatic wait_out1(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (nout1 >= n) return;
    end
    chk("u1_output_timeout", 32'(nout1), 32'(n));
  endtask

  initial begin
    int n0;
    int n1;
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0; ap0 = 1'b0; or0 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; ap1 = 1'b0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid0", 32'(ov0), 32'd0);
    chk("rst_out_diff0", 32'(d0), 32'd0);
    chk("rst_out_viol0", 32'(vi0), 32'd0);
    chk("rst_err_cnt0", 32'(ec0), 32'd0);
    chk("rst_err_max0", 32'(em0), 32'd0);
    chk("rst_out_valid1", 32'(ov1), 32'd0);
    chk("rst_in_ready0", 32'(r0), 32'd1);

    // 9-2 = 7 -> approx 6 with latency 2, exact 7
    beat0(9, 2, 1); idle0(); wait_out0(1);
    chk("t1_approx_diff", 32'(last0_diff), 32'd6);
    chk("t1_viol", 32'(last0_viol), 32'd0);
    chk("t1_latency", 32'(last0_lat), 32'd2);
    beat0(9, 2, 0); idle0(); wait_out0(2);
    chk("t1_exact_diff", 32'(last0_diff), 32'd7);

    // |3-12| = 9 -> 8 ; 5-5 -> 0, err_max stays at 1
    beat0(3, 12, 1); idle0(); wait_out0(3);
    chk("t2_diff", 32'(last0_diff), 32'd8);
    beat0(5, 5, 1); idle0(); wait_out0(4);
    chk("t2_equal_diff", 32'(last0_diff), 32'd0);
    @(negedge clk); #1;
    chk("t2_err_max", 32'(em0), MON ? 32'd1 : 32'd0);
    chk("t2_err_cnt", 32'(ec0), 32'd0);

    // TRUNC=3: 15 -> 8, err 7 violates
    beat1(15, 0, 1); idle1(); wait_out1(1);
    chk("t3_diff", 32'(last1_diff), 32'd8);
    chk("t3_viol", 32'(last1_viol), MON ? 32'd1 : 32'd0);
    @(negedge clk); #1;
    chk("t3_err_cnt", 32'(ec1), MON ? 32'd1 : 32'd0);
    chk("t3_err_max", 32'(em1), MON ? 32'd7 : 32'd0);

    // back-to-back stream with a 5-cycle consumer stall
    n0 = nout0;
    saw_low0 = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) beat0((i * 7 + 3) % 16, i, i % 2);
        idle0();
      end
      begin
        repeat (4) @(posedge clk);
        #1 or0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 or0 = 1'b1;
      end
    join
    wait_out0(n0 + 10);
    repeat (4) @(negedge clk);
    #1;
    chk("t4_beat_count", 32'(nout0), 32'(n0 + 10));
    chk("t4_in_ready_dropped", 32'(saw_low0), 32'd1);

    // four more violating beats: 11->8 err3, 7->0 err7, 14->8 err6, 15->8 err7
    beat1(11, 0, 1); beat1(7, 0, 1); beat1(15, 1, 1); beat1(0, 15, 1); idle1();
    wait_out1(5);
    @(negedge clk); #1;
    chk("t5_err_cnt_sat", 32'(ec1), MON ? 32'd3 : 32'd0);
    chk("t5_err_max", 32'(em1), MON ? 32'd7 : 32'd0);

    // reset with two beats held in flight
    or1 = 1'b0;
    beat1(9, 2, 1); beat1(4, 1, 1); idle1();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", 32'(ov1), 32'd0);
    chk("t5_rst_err_cnt", 32'(ec1), 32'd0);
    chk("t5_rst_err_max", 32'(em1), 32'd0);
    chk("t5_rst_out_diff", 32'(d1), 32'd0);
    n1 = nout1;
    or1 = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_no_stale_beats", 32'(nout1), 32'(n1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
